// File: rtl/be_mem_arbiter.sv
// be_mem_arbiter: round-robin owner of the single back-end memory port, with
// per-requester burst lock and a read-response watchdog. One transaction in flight.
module be_mem_arbiter #(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid_i,
    input  logic [NREQ-1:0]            req_lock_i,
    input  logic [NREQ*ADDR_W-1:0]     req_addr_i,
    input  logic [NREQ*DATA_W-1:0]     req_wdata_i,
    input  logic [NREQ*(DATA_W/8)-1:0] req_wstrb_i,
    output logic [NREQ-1:0]            req_ready_o,
    output logic [DATA_W-1:0]          req_rdata_o,
    output logic [NREQ-1:0]            req_rvalid_o,
    output logic                       be_valid_o,
    output logic [ADDR_W-1:0]          be_addr_o,
    output logic [DATA_W-1:0]          be_wdata_o,
    output logic [DATA_W/8-1:0]        be_wstrb_o,
    input  logic [DATA_W-1:0]          be_rdata_i,
    input  logic                       be_rvalid_i,
    input  logic                       be_ready_i,
    output logic [NREQ-1:0]            grant_o,
    output logic                       timeout_o
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RD_WAIT = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     g_q, g_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]      grant_q, grant_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

    logic                 own_valid;
    logic                 own_lock;
    logic [ADDR_W-1:0]    own_addr;
    logic [DATA_W-1:0]    own_wdata;
    logic [STRB_W-1:0]    own_wstrb;
    logic [IDX_W-1:0]     g_inc;
    logic [IDX_W-1:0]     rr_win;
    logic                 rr_any;
    logic                 rel_own;

    assign grant_o = grant_q;
    assign g_inc   = (32'(g_q) + 32'd1 >= NREQ) ? '0 : g_q + IDX_W'(1);

    // Request fields of the current owner
    always_comb begin
        own_valid = 1'b0;
        own_lock  = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        own_wstrb = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (g_q == IDX_W'(i)) begin
                own_valid = req_valid_i[i];
                own_lock  = req_lock_i[i];
                own_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                own_wdata = req_wdata_i[i*DATA_W +: DATA_W];
                own_wstrb = req_wstrb_i[i*STRB_W +: STRB_W];
            end
        end
    end

    // First valid requester at or after ptr, wrapping around
    always_comb begin
        rr_any = 1'b0;
        rr_win = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!rr_any && req_valid_i[i] && i >= 32'(ptr_q)) begin
                rr_any = 1'b1;
                rr_win = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!rr_any && req_valid_i[i]) begin
                rr_any = 1'b1;
                rr_win = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        wdog_d       = wdog_q;
        rel_own      = 1'b0;
        be_valid_o   = 1'b0;
        be_addr_o    = '0;
        be_wdata_o   = '0;
        be_wstrb_o   = '0;
        req_ready_o  = '0;
        req_rvalid_o = '0;
        req_rdata_o  = '0;
        timeout_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rr_any) begin
                    state_d = S_REQ;
                    g_d     = rr_win;
                    grant_d = NREQ'(1) << rr_win;
                end
            end
            S_REQ: begin
                be_valid_o  = own_valid;
                be_addr_o   = own_addr;
                be_wdata_o  = own_wdata;
                be_wstrb_o  = own_wstrb;
                req_ready_o = grant_q & {NREQ{be_ready_i}};
                if (!own_valid) begin
                    rel_own = 1'b1;
                end else if (be_ready_i) begin
                    if (|own_wstrb) begin
                        rel_own = !own_lock;
                    end else begin
                        state_d = S_RD_WAIT;
                        wdog_d  = '0;
                    end
                end
            end
            S_RD_WAIT: begin
                // A response arriving in the expiry cycle beats the watchdog
                if (be_rvalid_i) begin
                    req_rvalid_o = grant_q;
                    req_rdata_o  = be_rdata_i;
                    if (own_lock) begin
                        state_d = S_REQ;
                    end else begin
                        rel_own = 1'b1;
                    end
                end else if (wdog_q == WDOG_MAX) begin
                    timeout_o    = 1'b1;
                    req_rvalid_o = grant_q;
                    rel_own      = 1'b1;
                end else begin
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        if (rel_own) begin
            state_d = S_IDLE;
            grant_d = '0;
            ptr_d   = g_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_be_mem_arbiter.sv
// tb_be_mem_arbiter: vector table, directed corner sequences and a randomized run
// compared against a transaction-level model of the arbiter.
module tb_be_mem_arbiter;
    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned TW   = 4;
    localparam int TMAX = (1 << TW) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ-1:0]    req_lock_i;
    logic [NREQ*AW-1:0] req_addr_i;
    logic [NREQ*DW-1:0] req_wdata_i;
    logic [NREQ*SW-1:0] req_wstrb_i;
    logic [NREQ-1:0]    req_ready_o;
    logic [DW-1:0]      req_rdata_o;
    logic [NREQ-1:0]    req_rvalid_o;
    logic               be_valid_o;
    logic [AW-1:0]      be_addr_o;
    logic [DW-1:0]      be_wdata_o;
    logic [SW-1:0]      be_wstrb_o;
    logic [DW-1:0]      be_rdata_i;
    logic               be_rvalid_i;
    logic               be_ready_i;
    logic [NREQ-1:0]    grant_o;
    logic               timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    be_mem_arbiter #(
        .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_lock_i(req_lock_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .req_ready_o(req_ready_o), .req_rdata_o(req_rdata_o), .req_rvalid_o(req_rvalid_o),
        .be_valid_o(be_valid_o), .be_addr_o(be_addr_o), .be_wdata_o(be_wdata_o),
        .be_wstrb_o(be_wstrb_o), .be_rdata_i(be_rdata_i), .be_rvalid_i(be_rvalid_i),
        .be_ready_i(be_ready_i), .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic lk, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [SW-1:0] st);
        req_valid_i[r]          = v;
        req_lock_i[r]           = lk;
        req_addr_i[r*AW +: AW]  = a;
        req_wdata_i[r*DW +: DW] = wd;
        req_wstrb_i[r*SW +: SW] = st;
    endtask

    // Single read by requester r: arbitration, handshake, lat empty wait cycles,
    // then either a response (answer=1) or nothing; ends after the following IDLE cycle.
    task automatic do_read(input int r, input logic [AW-1:0] a, input int lat, input logic answer,
                           input logic [DW-1:0] data, input logic [NREQ-1:0] pend, input string tag);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << r;
        set_req(r, 1'b1, 1'b0, a, '0, '0);
        be_ready_i = 1'b1;
        @(negedge clk);
        chk({tag, "_arb_grant"}, grant_o, '0);
        next_cyc();
        @(negedge clk);
        chk({tag, "_req_grant"}, grant_o, oh);
        chk({tag, "_req_be"}, {be_valid_o, be_addr_o, be_wstrb_o}, {1'b1, a, 4'h0});
        chk({tag, "_req_ready"}, req_ready_o, oh);
        next_cyc();
        req_valid_i[r] = 1'b0;
        req_valid_i    = req_valid_i | pend;
        be_rdata_i     = data;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk({tag, "_wait"}, {req_rvalid_o, timeout_o, be_valid_o, grant_o}, {2'b00, 1'b0, 1'b0, oh});
            next_cyc();
        end
        be_rvalid_i = answer;
        @(negedge clk);
        chk({tag, "_rvalid"}, req_rvalid_o, oh);
        chk({tag, "_rdata"}, req_rdata_o, answer ? data : '0);
        chk({tag, "_timeout"}, timeout_o, !answer);
        next_cyc();
        be_rvalid_i = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, {grant_o, timeout_o, req_rvalid_o, req_rdata_o}, '0);
        next_cyc();
    endtask

    // Transaction-level reference: owner (-1 when free), outstanding read, wait count, pointer
    int m_owner;
    bit m_rd;
    int m_cnt;
    int m_ptr;

    task automatic model_cycle();
        logic [NREQ-1:0] e_grant, e_ready, e_rv;
        logic            e_bv, e_to;
        logic [AW-1:0]   e_addr;
        logic [DW-1:0]   e_wd, e_rd;
        logic [SW-1:0]   e_st;
        bit              rel;
        e_grant = '0; e_ready = '0; e_rv = '0; e_bv = 1'b0; e_to = 1'b0;
        e_addr = '0; e_wd = '0; e_rd = '0; e_st = '0; rel = 1'b0;
        if (m_owner >= 0) begin
            e_grant = NREQ'(1) << m_owner;
            if (!m_rd) begin
                e_bv    = req_valid_i[m_owner];
                e_addr  = req_addr_i[m_owner*AW +: AW];
                e_wd    = req_wdata_i[m_owner*DW +: DW];
                e_st    = req_wstrb_i[m_owner*SW +: SW];
                e_ready = be_ready_i ? e_grant : '0;
            end else if (be_rvalid_i) begin
                e_rv = e_grant;
                e_rd = be_rdata_i;
            end else if (m_cnt == TMAX) begin
                e_rv = e_grant;
                e_to = 1'b1;
            end
        end
        chk("rnd_grant", grant_o, e_grant);
        chk("rnd_ready", req_ready_o, e_ready);
        chk("rnd_be", {be_valid_o, be_addr_o, be_wdata_o, be_wstrb_o}, {e_bv, e_addr, e_wd, e_st});
        chk("rnd_resp", {req_rvalid_o, req_rdata_o, timeout_o}, {e_rv, e_rd, e_to});

        if (reset) begin
            m_owner = -1; m_rd = 1'b0; m_cnt = 0; m_ptr = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++)
                if (m_owner < 0 && req_valid_i[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
        end else if (!m_rd) begin
            if (!req_valid_i[m_owner]) rel = 1'b1;
            else if (be_ready_i) begin
                if (req_wstrb_i[m_owner*SW +: SW] != '0) rel = !req_lock_i[m_owner];
                else begin
                    m_rd = 1'b1;
                    m_cnt = 0;
                end
            end
        end else if (be_rvalid_i) begin
            m_rd = 1'b0;
            rel  = !req_lock_i[m_owner];
        end else if (m_cnt == TMAX) begin
            rel = 1'b1;
        end else begin
            m_cnt++;
        end
        if (rel) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
            m_rd    = 1'b0;
        end
    endtask

    typedef struct packed {
        logic [1:0]  valid;
        logic [1:0]  lock;
        logic        rdy;
        logic [1:0]  e_grant;
        logic [1:0]  e_ready;
        logic        e_bv;
        logic [3:0]  e_st;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int rv_pct;
        // Two writers, strobes 0xF / 0x3, starting from reset (pointer 0)
        tbl[0]  = '{2'b11, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 4'h0, 32'h0};
        tbl[1]  = '{2'b11, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1, 4'hF, 32'h200};
        tbl[2]  = '{2'b11, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 4'h0, 32'h0};
        tbl[3]  = '{2'b11, 2'b00, 1'b1, 2'b10, 2'b10, 1'b1, 4'h3, 32'h300};
        tbl[4]  = '{2'b11, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 4'h0, 32'h0};
        tbl[5]  = '{2'b11, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 4'hF, 32'h200};
        tbl[6]  = '{2'b11, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1, 4'hF, 32'h200};
        tbl[7]  = '{2'b11, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 4'h0, 32'h0};
        tbl[8]  = '{2'b11, 2'b10, 1'b1, 2'b10, 2'b10, 1'b1, 4'h3, 32'h300};
        tbl[9]  = '{2'b11, 2'b00, 1'b1, 2'b10, 2'b10, 1'b1, 4'h3, 32'h300};
        tbl[10] = '{2'b10, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 4'h0, 32'h0};
        tbl[11] = '{2'b00, 2'b00, 1'b1, 2'b10, 2'b10, 1'b0, 4'h3, 32'h300};
        tbl[12] = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 4'h0, 32'h0};
        tbl[13] = '{2'b01, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 4'h0, 32'h0};
        tbl[14] = '{2'b01, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1, 4'hF, 32'h200};
        tbl[15] = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 4'h0, 32'h0};

        reset = 1'b1;
        req_valid_i = '0; req_lock_i = '0; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
        be_rdata_i = '0; be_rvalid_i = 1'b0; be_ready_i = 1'b0;
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk("rst_grant", grant_o, '0);
        chk("rst_be", {be_valid_o, be_addr_o, be_wdata_o, be_wstrb_o}, '0);
        chk("rst_resp", {req_ready_o, req_rvalid_o, req_rdata_o, timeout_o}, '0);
        next_cyc();
        reset = 1'b0;

        set_req(0, 1'b0, 1'b0, 32'h200, 32'hF0F0_0000, 4'hF);
        set_req(1, 1'b0, 1'b0, 32'h300, 32'h0303_0303, 4'h3);
        for (int i = 0; i < 16; i++) begin
            req_valid_i = tbl[i].valid;
            req_lock_i  = tbl[i].lock;
            be_ready_i  = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_grant", i), grant_o, tbl[i].e_grant);
            chk($sformatf("tbl%0d_ready", i), req_ready_o, tbl[i].e_ready);
            chk($sformatf("tbl%0d_bvalid", i), be_valid_o, tbl[i].e_bv);
            chk($sformatf("tbl%0d_wstrb", i), be_wstrb_o, tbl[i].e_st);
            chk($sformatf("tbl%0d_addr", i), be_addr_o, tbl[i].e_addr);
            next_cyc();
        end
        req_lock_i = '0;

        do_read(0, 32'h100, 2, 1'b1, 32'hDEAD_BEEF, 2'b00, "rd");

        // Locked 16-beat line fill by req1 with req0 waiting
        set_req(0, 1'b1, 1'b0, 32'h200, 32'h0000_00A0, 4'hF);
        set_req(1, 1'b1, 1'b1, 32'h1000, '0, 4'h0);
        be_ready_i = 1'b1;
        @(negedge clk);
        chk("burst_arb", grant_o, '0);
        next_cyc();
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            chk("burst_grant", grant_o, 2'b10);
            chk("burst_addr", {be_valid_o, be_addr_o}, {1'b1, 32'h1000 + 32'(4 * b)});
            chk("burst_ready", req_ready_o, 2'b10);
            next_cyc();
            req_lock_i[1] = (b != 15);
            if (b == 15) req_valid_i[1] = 1'b0;
            @(negedge clk);
            chk("burst_wait", {grant_o, be_valid_o}, {2'b10, 1'b0});
            next_cyc();
            be_rvalid_i = 1'b1;
            be_rdata_i  = 32'hB000 + 32'(b);
            @(negedge clk);
            chk("burst_rvalid", req_rvalid_o, 2'b10);
            chk("burst_rdata", req_rdata_o, 32'hB000 + 32'(b));
            next_cyc();
            be_rvalid_i = 1'b0;
            req_addr_i[AW +: AW] = 32'h1000 + 32'(4 * (b + 1));
        end
        @(negedge clk);
        chk("burst_after_arb", grant_o, '0);
        next_cyc();
        @(negedge clk);
        chk("burst_req0_grant", grant_o, 2'b01);
        chk("burst_req0_be", {be_valid_o, be_addr_o, be_wstrb_o}, {1'b1, 32'h200, 4'hF});
        next_cyc();
        req_valid_i[0] = 1'b0;
        @(negedge clk);
        chk("burst_req0_done", grant_o, '0);
        next_cyc();

        // Unanswered read: watchdog expiry, then pending req1 is served
        set_req(1, 1'b0, 1'b0, 32'h300, 32'h3333_0000, 4'h3);
        do_read(0, 32'h400, TMAX, 1'b0, 32'hCAFE_F00D, 2'b10, "tmo");
        @(negedge clk);
        chk("tmo_pending_grant", grant_o, 2'b10);
        chk("tmo_pending_be", {be_valid_o, be_wstrb_o, be_wdata_o, timeout_o}, {1'b1, 4'h3, 32'h3333_0000, 1'b0});
        next_cyc();
        req_valid_i[1] = 1'b0;
        @(negedge clk);
        chk("tmo_pending_done", grant_o, '0);
        next_cyc();

        // Response lands exactly in the expiry cycle
        do_read(1, 32'h480, TMAX, 1'b1, 32'h1234_5678, 2'b00, "exp");

        // Backpressure on a write
        set_req(0, 1'b1, 1'b0, 32'h500, 32'hA5A5_5A5A, 4'hF);
        be_ready_i = 1'b0;
        @(negedge clk);
        chk("bp_arb", grant_o, '0);
        next_cyc();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold", {grant_o, req_ready_o, be_valid_o, be_addr_o, be_wdata_o},
                {2'b01, 2'b00, 1'b1, 32'h500, 32'hA5A5_5A5A});
            next_cyc();
        end
        be_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_accept", {grant_o, req_ready_o, be_valid_o}, {2'b01, 2'b01, 1'b1});
        next_cyc();
        req_valid_i[0] = 1'b0;
        @(negedge clk);
        chk("bp_done", grant_o, '0);
        next_cyc();

        // Reset while a read is outstanding, then a late response
        set_req(1, 1'b1, 1'b0, 32'h600, '0, 4'h0);
        @(negedge clk);
        next_cyc();
        @(negedge clk);
        chk("rstrd_req", {grant_o, be_valid_o}, {2'b10, 1'b1});
        next_cyc();
        req_valid_i[1] = 1'b0;
        @(negedge clk);
        chk("rstrd_wait", {grant_o, be_valid_o}, {2'b10, 1'b0});
        next_cyc();
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        be_rvalid_i = 1'b1;
        be_rdata_i  = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("rstrd_late", {grant_o, req_rvalid_o, req_rdata_o, timeout_o, be_valid_o}, '0);
        next_cyc();
        be_rvalid_i = 1'b0;

        // Randomized run against the reference model
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        m_owner = -1; m_rd = 1'b0; m_cnt = 0; m_ptr = 0;
        rv_pct = 30;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) rv_pct = ($urandom_range(0, 1) == 1) ? 3 : 40;
            reset = ($urandom_range(0, 299) == 0);
            for (int r = 0; r < NREQ; r++)
                set_req(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom, $urandom,
                        ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0);
            be_ready_i  = $urandom_range(0, 3) != 0;
            be_rvalid_i = $urandom_range(0, 99) < rv_pct;
            be_rdata_i  = $urandom;
            @(negedge clk);
            model_cycle();
            next_cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
